// File: rtl/mux_rr.sv
// rtl/mux_rr.sv - registered N-channel selector, fixed or round-robin grant, valid/ready handshakes
// Optional 2-entry skid buffer behind the output register: define MUX_RR_SKID_EN.
module mux_rr #(
    parameter int WIDTH = 5,
    parameter int SEL_W = 3,
    localparam int CHANNELS = 2 ** SEL_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          Sel,
    input  logic [CHANNELS-1:0]       In_valid,
    input  logic [CHANNELS*WIDTH-1:0] In_data,
    output logic [CHANNELS-1:0]       In_ready,
    output logic [WIDTH-1:0]          Out,
    output logic [SEL_W-1:0]          Out_chan,
    output logic                      Out_valid,
    input  logic                      Out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] cand;
    logic [WIDTH-1:0] grant_data;
    logic             slot_free;
    logic             accept;

`ifdef MUX_RR_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_chan_q, skid_chan_d;
    logic             skid_full_q, skid_full_d;

    assign slot_free = !skid_full_q;
`else
    assign slot_free = !out_valid_q || Out_ready;
`endif

    // Descending scan so the smallest offset from last_q wins; offset CHANNELS wraps to last_q itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!mode) begin
            grant_vld = In_valid[Sel];
            grant_idx = Sel;
        end else begin
            for (int i = CHANNELS; i >= 1; i--) begin
                cand = last_q + SEL_W'(i);
                if (In_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign grant_data = In_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign accept     = grant_vld && slot_free;

    always_comb begin
        In_ready = '0;
        if (accept) begin
            In_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = accept ? grant_idx : last_q;
`ifdef MUX_RR_SKID_EN
        skid_data_d = skid_data_q;
        skid_chan_d = skid_chan_q;
        skid_full_d = skid_full_q;
        if (out_valid_q && Out_ready) begin
            if (skid_full_q) begin
                out_data_d  = skid_data_q;
                out_chan_d  = skid_chan_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (accept) begin
                out_data_d  = grant_data;
                out_chan_d  = grant_idx;
                out_valid_d = 1'b1;
            end
        end else if (accept) begin
            skid_data_d = grant_data;
            skid_chan_d = grant_idx;
            skid_full_d = 1'b1;
        end
`else
        if (accept) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
        end else if (Out_ready) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SEL_W'(CHANNELS - 1);
`ifdef MUX_RR_SKID_EN
            skid_data_q <= '0;
            skid_chan_q <= '0;
            skid_full_q <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
`ifdef MUX_RR_SKID_EN
            skid_data_q <= skid_data_d;
            skid_chan_q <= skid_chan_d;
            skid_full_q <= skid_full_d;
`endif
        end
    end

    assign Out       = out_data_q;
    assign Out_chan  = out_chan_q;
    assign Out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr.sv
// tb/tb_mux_rr.sv - directed self-checking bench for mux_rr
module tb_mux_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [2:0]  Sel;
    logic [7:0]  In_valid;
    logic [39:0] In_data;
    logic [7:0]  In_ready;
    logic [4:0]  Out;
    logic [2:0]  Out_chan;
    logic        Out_valid;
    logic        Out_ready;

    int checks   = 0;
    int failures = 0;

    logic [4:0] tbl [8] = '{5'h01, 5'h03, 5'h05, 5'h07, 5'h09, 5'h1A, 5'h0D, 5'h0F};

    mux_rr dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .Sel       (Sel),
        .In_valid  (In_valid),
        .In_data   (In_data),
        .In_ready  (In_ready),
        .Out       (Out),
        .Out_chan  (Out_chan),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        In_valid = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mode      = 1'b0;
        Sel       = 3'd0;
        In_valid  = 8'h00;
        Out_ready = 1'b0;
        tick();
        tick();
        checks += 4;
        if (Out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Out_valid); end
        if (Out !== 5'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", Out); end
        if (Out_chan !== 3'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", Out_chan); end
        if (In_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got=%h exp=00", In_ready); end
        reset = 1'b0;
    endtask

    task automatic test_fixed_select();
        mode      = 1'b0;
        Sel       = 3'd5;
        In_valid  = 8'h20;
        Out_ready = 1'b1;
        #1;
        checks++;
        if (In_ready !== 8'h20) begin failures++; $display("FAIL fixed_in_ready got=%h exp=20", In_ready); end
        tick();
        checks += 3;
        if (Out !== 5'h1A) begin failures++; $display("FAIL fixed_out got=%h exp=1a", Out); end
        if (Out_chan !== 3'd5) begin failures++; $display("FAIL fixed_chan got=%0d exp=5", Out_chan); end
        if (Out_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid got=%b exp=1", Out_valid); end
        // Valid on an unselected channel must be ignored; output drains and holds data.
        Sel = 3'd2;
        #1;
        checks++;
        if (In_ready !== 8'h00) begin failures++; $display("FAIL fixed_ignore_ready got=%h exp=00", In_ready); end
        tick();
        checks += 3;
        if (Out_valid !== 1'b0) begin failures++; $display("FAIL fixed_drain_valid got=%b exp=0", Out_valid); end
        if (Out !== 5'h1A) begin failures++; $display("FAIL fixed_hold_out got=%h exp=1a", Out); end
        if (Out_chan !== 3'd5) begin failures++; $display("FAIL fixed_hold_chan got=%0d exp=5", Out_chan); end
    endtask

    task automatic test_rr_fairness();
        pulse_reset();
        mode      = 1'b1;
        In_valid  = 8'hFF;
        Out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int e;
            e = i % 8;
            #1;
            checks++;
            if (In_ready !== (8'h01 << e)) begin failures++; $display("FAIL rr_ready[%0d] got=%h exp=%h", i, In_ready, 8'h01 << e); end
            tick();
            checks += 2;
            if (Out_chan !== 3'(e)) begin failures++; $display("FAIL rr_chan[%0d] got=%0d exp=%0d", i, Out_chan, e); end
            if (Out !== tbl[e]) begin failures++; $display("FAIL rr_out[%0d] got=%h exp=%h", i, Out, tbl[e]); end
        end
    endtask

    task automatic test_sparse_wrap();
        int seq [4] = '{1, 7, 1, 7};
        pulse_reset();
        mode      = 1'b1;
        In_valid  = 8'b1000_0010;
        Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (Out_chan !== 3'(seq[i])) begin failures++; $display("FAIL sparse_chan[%0d] got=%0d exp=%0d", i, Out_chan, seq[i]); end
            if (Out_valid !== 1'b1) begin failures++; $display("FAIL sparse_valid[%0d] got=%b exp=1", i, Out_valid); end
        end
    endtask

`ifndef MUX_RR_SKID_EN
    task automatic test_backpressure();
        pulse_reset();
        mode      = 1'b1;
        In_valid  = 8'hFF;
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (In_ready !== 8'h00) begin failures++; $display("FAIL bp_ready[%0d] got=%h exp=00", i, In_ready); end
            tick();
            checks += 3;
            if (Out_chan !== 3'd0) begin failures++; $display("FAIL bp_chan[%0d] got=%0d exp=0", i, Out_chan); end
            if (Out !== tbl[0]) begin failures++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, Out, tbl[0]); end
            if (Out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, Out_valid); end
        end
        Out_ready = 1'b1;
        #1;
        checks++;
        if (In_ready !== 8'h02) begin failures++; $display("FAIL bp_release_ready got=%h exp=02", In_ready); end
        tick();
        checks += 2;
        if (Out_chan !== 3'd1) begin failures++; $display("FAIL bp_next_chan got=%0d exp=1", Out_chan); end
        if (Out !== tbl[1]) begin failures++; $display("FAIL bp_next_out got=%h exp=%h", Out, tbl[1]); end
    endtask
`endif

    task automatic test_reset_mid_stall();
        pulse_reset();
        mode      = 1'b0;
        Sel       = 3'd3;
        In_valid  = 8'h08;
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        tick();
        checks++;
        if (Out_chan !== 3'd3) begin failures++; $display("FAIL stall_setup_chan got=%0d exp=3", Out_chan); end
        mode     = 1'b1;
        In_valid = 8'hFF;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        checks += 3;
        if (Out_valid !== 1'b0) begin failures++; $display("FAIL stall_reset_valid got=%b exp=0", Out_valid); end
        if (Out !== 5'h00) begin failures++; $display("FAIL stall_reset_out got=%h exp=00", Out); end
        if (Out_chan !== 3'd0) begin failures++; $display("FAIL stall_reset_chan got=%0d exp=0", Out_chan); end
        Out_ready = 1'b1;
        #1;
        checks++;
        if (In_ready !== 8'h01) begin failures++; $display("FAIL stall_first_ready got=%h exp=01", In_ready); end
        tick();
        checks++;
        if (Out_chan !== 3'd0) begin failures++; $display("FAIL stall_first_chan got=%0d exp=0", Out_chan); end
    endtask

`ifdef MUX_RR_SKID_EN
    task automatic test_skid();
        int ng = 0;
        int no = 0;
        pulse_reset();
        mode     = 1'b1;
        In_valid = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            logic [7:0] pre;
            Out_ready = (c % 2 == 0) || (c >= 12);
            if (c >= 12) In_valid = 8'h00;
            #1;
            pre = In_ready;
            Out_ready = ~Out_ready;
            #1;
            checks++;
            if (In_ready !== pre) begin failures++; $display("FAIL skid_comb_ready[%0d] got=%h exp=%h", c, In_ready, pre); end
            Out_ready = ~Out_ready;
            #1;
            if (In_ready != 8'h00) begin
                checks++;
                if (In_ready !== (8'h01 << (ng % 8))) begin failures++; $display("FAIL skid_grant[%0d] got=%h exp=%h", ng, In_ready, 8'h01 << (ng % 8)); end
                ng++;
            end
            if (Out_valid && Out_ready) begin
                checks++;
                if (Out_chan !== 3'(no % 8)) begin failures++; $display("FAIL skid_order[%0d] got=%0d exp=%0d", no, Out_chan, no % 8); end
                no++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (no !== ng) begin failures++; $display("FAIL skid_count got=%0d exp=%0d", no, ng); end
    endtask
`endif

    initial begin
        In_data = '0;
        for (int k = 0; k < 8; k++) In_data[k*5 +: 5] = tbl[k];
        test_reset();
        test_fixed_select();
        test_rr_fairness();
        test_sparse_wrap();
`ifndef MUX_RR_SKID_EN
        test_backpressure();
`endif
        test_reset_mid_stall();
`ifdef MUX_RR_SKID_EN
        test_skid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr.md
# mux_rr

Parametrised, registered N-channel selector with valid/ready handshakes. It is the successor to the fixed 8:1 5-bit combinational mux. Each input channel presents data with a valid flag. The block picks one channel per cycle, either by an explicit `Sel` or by round-robin arbitration, and delivers it through a registered output stage. It sits between multiple producers (register-index sources, forwarding paths, bus masters) and a single consumer that may stall.

## Interface
- `WIDTH`, default 5: data width per channel.
- `SEL_W`, default 3: select width; `CHANNELS = 2**SEL_W`, so 8 by default.
- `clk` input, 1 bit: the only clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `mode` input, 1 bit: 0 = fixed select via `Sel`; 1 = round-robin.
- `Sel` input, `SEL_W` bits: channel index, used only when `mode`=0.
- `In_valid` input, `CHANNELS` bits: per-channel valid.
- `In_data` input, `CHANNELS*WIDTH` bits: flattened; channel k is at `[k*WIDTH +: WIDTH]`.
- `In_ready` output, `CHANNELS` bits: per-channel accept. At most one bit is high per cycle.
- `Out` output, `WIDTH` bits: registered data.
- `Out_chan` output, `SEL_W` bits: index of the channel that produced `Out`.
- `Out_valid` output, 1 bit: `Out`/`Out_chan` hold a transfer.
- `Out_ready` input, 1 bit: the consumer accepts when both `Out_valid` and `Out_ready` are high.

## Operation
- **Reset values:** `Out_valid`=0, `Out`=0, `Out_chan`=0, `In_ready`=0. The round-robin pointer `last` resets to `CHANNELS-1`, so channel 0 has first priority after reset.
- **`slot_free`:** no skid (see Configuration): `slot_free = !Out_valid || Out_ready`.
- **Grant, `mode`=0:** `grant = Sel` if `In_valid[Sel]`, else no grant. Valid on other channels is ignored and never acknowledged.
- **Grant, `mode`=1:** scan `last+1, last+2, …`, wrapping modulo `CHANNELS`. The first channel with `In_valid` set wins. No valid channels means no grant.
- **Ready:** `In_ready[k] = slot_free && grant==k`.
- **Accept:** occurs when a grant exists and `slot_free` is high. On accept, the output register loads `In_data[grant]`, `Out_chan` loads `grant`, and `Out_valid` is set.
- **Pointer update:** `last` is set to the granted index on every accept, in either mode. Switching modes therefore continues round-robin fairness from the last served channel.
- **Output without accept:** if `Out_ready` is high and there is no accept, `Out_valid` clears on the next edge. `Out` and `Out_chan` hold their last values.
- **Stall:** while `Out_valid && !Out_ready`, `Out`, `Out_chan` and `Out_valid` are stable, and all `In_ready` bits are 0.
- **Changes mid-transfer:** `mode` and `Sel` are sampled every cycle. A change affects only the next grant; the held output is never modified.
- **Input-side rule:** a producer must keep data stable while valid and not yet readied. Dropping valid before ready is legal; nothing is captured.
- **`reset` precedence:** `reset` overrides everything, including a simultaneous accept. In-flight data is discarded.

## Timing
- Latency: 1 cycle from the accept edge to `Out_valid`=1.
- Throughput: 1 transfer per cycle while `Out_ready` is held high.
- Without `MUX_RR_SKID_EN`, `In_ready` depends combinationally on `Out_ready`, `In_valid`, `mode` and `Sel`.
- `Out`, `Out_chan` and `Out_valid` are always driven directly by flops.
- Arbitration is one combinational priority scan of `CHANNELS` entries; there is no multi-cycle search.

## Configuration
- **`MUX_RR_SKID_EN` undefined:** single output register, behaviour exactly as above.
- **`MUX_RR_SKID_EN` defined:** a 2-entry skid buffer is added behind the output register.
  - `slot_free` becomes `!skid_full`, a flop, so `In_ready` no longer depends combinationally on `Out_ready`.
  - An accept while `Out_valid && !Out_ready` stores the word into the skid entry.
  - When the consumer takes the main entry, the skid entry moves into the main entry on the same edge.
  - Ordering is preserved. Latency remains 1 cycle; throughput remains 1 per cycle.
  - Reset clears the skid entry.

## Test plan
- **Reset and fixed select:** `reset` high for 2 cycles, then `mode`=0, `Sel`=5, `In_valid`=8'h20, ch5 data=5'h1A, `Out_ready`=1. Required: `In_ready`=8'h20 in the same cycle; next cycle `Out`=5'h1A, `Out_chan`=5, `Out_valid`=1.
- **Round-robin fairness:** `mode`=1, `In_valid`=8'hFF held, `Out_ready`=1 for 10 cycles. Required: `Out_chan` sequence 0,1,…,7,0,1, with no channel repeated before all others are served.
- **Sparse round-robin with wrap:** `In_valid`=8'b1000_0010. Required: grants alternate 1,7,1,7; after serving 7, the scan wraps to 1.
- **Backpressure:** after a valid output, `Out_ready`=0 for 3 cycles. Required: `Out`/`Out_chan` stable, `In_ready`=0 throughout; on release, the next word appears the following cycle with nothing lost or duplicated.
- **Reset mid-stall:** `Out_valid`=1, `Out_ready`=0, assert `reset`. Required: next cycle `Out_valid`=0, `Out`=0, and channel 0 is granted first afterwards.
- **Skid (`MUX_RR_SKID_EN`):** `Out_ready` toggled 1,0,1,0 with all channels valid. Required: `In_ready` does not follow `Out_ready` combinationally, and the output order equals the grant order with no loss.
